// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: Clk/2 pixel clock, syncs, active-video flag and DrawX/DrawY.
// Optional `VGA_FRAME_COUNT_EN adds an 8-bit frame counter output (frame_count).
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pixel_clk,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       sync,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [7:0] frame_count
`endif
);

    // Totals must stay <= 1024 so both counters fit in 10 bits.
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic       r_pixel_clk;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_hs;
    logic       r_vs;
    logic       r_blank;
    logic       r_line_start;
    logic       r_frame_start;

    logic       w_pix_ce;
    logic       w_x_wrap;
    logic       w_y_wrap;
    logic [9:0] w_x_next;
    logic [9:0] w_y_next;
    logic       w_hs_next;
    logic       w_vs_next;
    logic       w_blank_next;

    // Outputs are decoded from the next counter values so that, once registered,
    // they line up with the DrawX/DrawY they describe.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_pix_ce = r_pixel_clk;
        w_x_wrap = 1'b0;
        w_y_wrap = 1'b0;
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_pix_ce) begin
            if (r_x == H_LAST) begin
                w_x_wrap = 1'b1;
                w_x_next = 10'd0;
                if (r_y == V_LAST) begin
                    w_y_wrap = 1'b1;
                    w_y_next = 10'd0;
                end else begin
                    w_y_next = r_y + 10'd1;
                end
            end else begin
                w_x_next = r_x + 10'd1;
            end
        end
        w_hs_next    = !((w_x_next >= HS_FIRST) && (w_x_next <= HS_LAST));
        w_vs_next    = !((w_y_next >= VS_FIRST) && (w_y_next <= VS_LAST));
        w_blank_next = (w_x_next < H_VIS) && (w_y_next < V_VIS);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pixel_clk   <= 1'b0;
            r_x           <= 10'd0;
            r_y           <= 10'd0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank       <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_pixel_clk   <= ~r_pixel_clk;
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_hs          <= w_hs_next;
            r_vs          <= w_vs_next;
            r_blank       <= w_blank_next;
            r_line_start  <= w_x_wrap;
            r_frame_start <= w_x_wrap && w_y_wrap;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] r_frame_count;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_frame_count <= 8'd0;
        end else if (w_x_wrap && w_y_wrap) begin
            r_frame_count <= r_frame_count + 8'd1;
        end
    end

    assign frame_count = r_frame_count;
`endif

    assign pixel_clk   = r_pixel_clk;
    assign DrawX       = r_x;
    assign DrawY       = r_y;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign blank       = r_blank;
    assign sync        = 1'b0;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a shrunken raster so many frames fit in a short run.
module tb_vga_timing_gen;

    localparam int HV = 16, HF = 3, HS = 4, HB = 5;
    localparam int VV = 10, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;   // 28
    localparam int VT = VV + VF + VS + VB;   // 17
    localparam int FRAME_CLKS = 2 * HT * VT; // 952

    logic       Clk = 1'b0;
    logic       Reset;
    logic       pixel_clk, hs, vs, blank, sync, line_start, frame_start;
    logic [9:0] DrawX, DrawY;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] frame_count;
`endif

    int total = 0;
    int bad   = 0;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .pixel_clk   (pixel_clk),
        .hs          (hs),
        .vs          (vs),
        .blank       (blank),
        .sync        (sync),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .line_start  (line_start),
        .frame_start (frame_start)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_count (frame_count)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the raster position is a pure function of Clk edges since reset release.
    int n;
    always @(posedge Clk or posedge Reset) begin
        if (Reset) n <= 0;
        else       n <= n + 1;
    end

    int  m_p, m_x, m_y;
    bit  m_ce_edge;
    always @(negedge Clk) begin
        m_p       = n / 2;
        m_x       = m_p % HT;
        m_y       = (m_p / HT) % VT;
        m_ce_edge = (n >= 2) && (n % 2 == 0);
        check("pixel_clk", pixel_clk, n % 2);
        check("DrawX", DrawX, m_x);
        check("DrawY", DrawY, m_y);
        check("hs", hs, !(m_x >= HV + HF && m_x < HV + HF + HS));
        check("vs", vs, !(m_y >= VV + VF && m_y < VV + VF + VS));
        check("blank", blank, (m_x < HV) && (m_y < VV));
        check("sync", sync, 0);
        check("line_start", line_start, m_ce_edge && m_x == 0);
        check("frame_start", frame_start, m_ce_edge && m_x == 0 && m_y == 0);
`ifdef VGA_FRAME_COUNT_EN
        check("frame_count", frame_count, (m_p / (HT * VT)) % 256);
`endif
    end

    // Hand-computed pins on the model: pulse spacing, sync widths, wrap corner.
    int cyc = 0, last_ls = 0, last_fs = 0, hs_lo = 0, vs_lo = 0;
    bit ls_valid = 0, fs_valid = 0;
    always @(negedge Clk) begin
        if (Reset) begin
            ls_valid = 0;
            fs_valid = 0;
            hs_lo    = 0;
            vs_lo    = 0;
        end else begin
            cyc++;
            if (line_start) begin
                if (ls_valid) begin
                    check("line_spacing", cyc - last_ls, 56);
                    check("hs_low_clks", hs_lo, 8);
                end
                ls_valid = 1;
                last_ls  = cyc;
                hs_lo    = 0;
            end
            if (frame_start) begin
                check("corner_line_start", line_start, 1);
                check("corner_x", DrawX, 0);
                check("corner_y", DrawY, 0);
                check("corner_blank", blank, 1);
                check("corner_hs", hs, 1);
                check("corner_vs", vs, 1);
                if (fs_valid) begin
                    check("frame_spacing", cyc - last_fs, 952);
                    check("vs_low_clks", vs_lo, 112);
                end
                fs_valid = 1;
                last_fs  = cyc;
                vs_lo    = 0;
            end
            if (!hs) hs_lo++;
            if (!vs) vs_lo++;
        end
    end

    initial begin
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        #1 Reset = 1'b0;

        @(posedge Clk);
        @(posedge Clk);
        #1 check("x_after_edge2", DrawX, 1);
        @(posedge Clk);
        @(posedge Clk);
        #1 check("x_after_edge4", DrawX, 2);

        repeat (3 * FRAME_CLKS + 20) @(negedge Clk);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(50, 1500)) @(negedge Clk);
            @(posedge Clk);
            #2 Reset = 1'b1;
            #1;
            check("rst_pixel_clk", pixel_clk, 0);
            check("rst_x", DrawX, 0);
            check("rst_y", DrawY, 0);
            check("rst_hs", hs, 1);
            check("rst_vs", vs, 1);
            check("rst_blank", blank, 1);
            check("rst_sync", sync, 0);
            check("rst_line_start", line_start, 0);
            check("rst_frame_start", frame_start, 0);
            repeat ($urandom_range(1, 4)) @(negedge Clk);
            #1 Reset = 1'b0;
        end

        repeat (2 * FRAME_CLKS + 20) @(negedge Clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
